// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared defaults and the video FSM state type for the
// data_mem_arb slice (arbiter top, bus interface, single-port RAM).
// Optional build macro: DATA_MEM_BYTE_WRITE_EN (byte-enabled CPU writes).
package data_mem_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_LEN_W      = 8;
  localparam int unsigned DEF_STARVE_MAX = 4;

  // Video burst FSM; vid_busy is high exactly in V_RUN.
  typedef enum logic [0:0] {
    V_IDLE = 1'b0,
    V_RUN  = 1'b1
  } vid_state_e;

endpackage

// File: rtl/data_mem_arb_if.sv
// data_mem_arb_if: CPU access port and video burst port of data_mem_arb.
//   master: CPU/video requester side (drives requests, receives data)
//   slave : arbiter side
//   CPU   : cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ready
//   video : vid_start, vid_base, vid_len -> vid_busy, vid_valid, vid_data, vid_last
interface data_mem_arb_if
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_W/8-1:0]   cpu_be;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_ready;

  logic                  vid_start;
  logic [ADDR_W-1:0]     vid_base;
  logic [LEN_W-1:0]      vid_len;
  logic                  vid_busy;
  logic                  vid_valid;
  logic [DATA_W-1:0]     vid_data;
  logic                  vid_last;

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output vid_start, vid_base, vid_len,
    input  cpu_rdata, cpu_ready,
    input  vid_busy, vid_valid, vid_data, vid_last
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  vid_start, vid_base, vid_len,
    output cpu_rdata, cpu_ready,
    output vid_busy, vid_valid, vid_data, vid_last
  );

endinterface

// File: rtl/data_mem_array.sv
// data_mem_array: single-port RAM, 2**ADDR_W words of DATA_W bits.
// Combinational read of the addressed word; write at the clock edge.
// Ports: clk, we, be (byte enables), addr, wdata, rdata_c.
// Macro DATA_MEM_BYTE_WRITE_EN: write only bytes with be=1; otherwise be is
// ignored and full words are written. Contents are never reset.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata_c = mem[addr];

`ifdef DATA_MEM_BYTE_WRITE_EN
  // Byte-lane write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
`else
  logic unused_be;
  assign unused_be = ^be;

  // Full-word write
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
`endif

endmodule

// File: rtl/data_mem_arb.sv
// data_mem_arb: arbitrates one single-port data memory between a CPU port and
// a video burst reader. CPU has priority unless it has taken STARVE_MAX
// consecutive slots while a burst is pending; then the video beat goes first.
// Ports: clk, reset (sync, active-high), bus (data_mem_arb_if.slave).
// Macro DATA_MEM_BYTE_WRITE_EN: honour cpu_be on writes (see data_mem_array).
module data_mem_arb
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_arb_if.slave  bus
);

  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  vid_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vid_valid_q, vid_valid_d;
  logic              vid_last_q, vid_last_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;

  logic              cpu_gnt_c;
  logic              vid_gnt_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_rdata_c;

  // Slot owner for this cycle; the memory port follows the winner
  assign cpu_gnt_c  = bus.cpu_req && !((state_q == V_RUN) && (starve_q == STARVE_LIM));
  assign vid_gnt_c  = (state_q == V_RUN) && !cpu_gnt_c;
  assign mem_we_c   = cpu_gnt_c && bus.cpu_we;
  assign mem_addr_c = cpu_gnt_c ? bus.cpu_addr : ptr_q;

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we      (mem_we_c),
    .be      (bus.cpu_be),
    .addr    (mem_addr_c),
    .wdata   (bus.cpu_wdata),
    .rdata_c (mem_rdata_c)
  );

  // Next state, burst pointer/counter, starvation counter and output pulses
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    starve_d    = starve_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_valid_d = 1'b0;
    vid_last_d  = 1'b0;
    vid_data_d  = vid_data_q;

    if (cpu_gnt_c) begin
      cpu_ready_d = 1'b1;
      if (!bus.cpu_we) cpu_rdata_d = mem_rdata_c;
    end

    case (state_q)
      V_IDLE: begin
        starve_d = '0;
        if (bus.vid_start && (bus.vid_len != '0)) begin
          state_d = V_RUN;
          ptr_d   = bus.vid_base;
          rem_d   = bus.vid_len;
        end
      end
      V_RUN: begin
        if (cpu_gnt_c) starve_d = starve_q + SW'(1);
        if (vid_gnt_c) begin
          starve_d    = '0;
          ptr_d       = ptr_q + ADDR_W'(1);
          rem_d       = rem_q - LEN_W'(1);
          vid_valid_d = 1'b1;
          vid_data_d  = mem_rdata_c;
          if (rem_q == LEN_W'(1)) begin
            vid_last_d = 1'b1;
            state_d    = V_IDLE;
          end
        end
      end
      default: state_d = V_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= V_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      starve_q    <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_last_q  <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      starve_q    <= starve_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_valid_q <= vid_valid_d;
      vid_last_q  <= vid_last_d;
      vid_data_q  <= vid_data_d;
    end
  end

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_busy  = (state_q == V_RUN);
  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_last  = vid_last_q;
  assign bus.vid_data  = vid_data_q;

endmodule

// File: tb/tb_data_mem_arb.sv
// tb_data_mem_arb: scoreboard bench for data_mem_arb. CPU operations are queued
// and driven by a background process; expected read data and video beats are
// computed from a bench-side memory model when stimulus is issued and compared
// when the DUT produces cpu_ready / vid_valid.
module tb_data_mem_arb;
  import data_mem_pkg::*;

  localparam int unsigned DW   = DEF_DATA_W;
  localparam int unsigned AW   = DEF_ADDR_W;
  localparam int unsigned LW   = DEF_LEN_W;
  localparam int unsigned NB   = DW / 8;
`ifdef DATA_MEM_BYTE_WRITE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] be;
  } cpu_op_t;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
  } cpu_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } vid_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_arb_if bus ();

  data_mem_arb #(.STARVE_MAX(DEF_STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int denials = 0;
  logic cur_active = 1'b0;

  logic [DW-1:0] model [1 << AW];
  cpu_op_t  cpu_ops[$];
  cpu_exp_t cpu_sb[$];
  vid_exp_t vid_sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (!BYTE_EN || be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8'hC3, a, ~a, 8'h5A};
  endfunction

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    cpu_op_t op;
    op.we = 1'b1; op.addr = a; op.data = d; op.be = be;
    cpu_ops.push_back(op);
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a);
    cpu_op_t op;
    op.we = 1'b0; op.addr = a; op.data = '0; op.be = '0;
    cpu_ops.push_back(op);
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_cpu_idle();
    int k;
    k = 0;
    while ((cpu_ops.size() != 0 || cur_active) && k < 500) begin
      @(negedge clk); #2;
      k++;
    end
    check("cpu_idle_timeout", 64'(k < 500), 64'(1));
  endtask

  task automatic wait_vid_idle();
    int k;
    k = 0;
    while ((bus.vid_busy || vid_sb.size() != 0) && k < 200) begin
      @(negedge clk); #2;
      k++;
    end
    check("vid_idle_timeout", 64'(k < 200), 64'(1));
  endtask

  // Drive a one-cycle vid_start; push expected beats when the bench expects acceptance
  task automatic vid_burst(input logic [AW-1:0] base, input logic [LW-1:0] len, input bit accept);
    logic [AW-1:0] a;
    vid_exp_t e;
    bus.vid_start = 1'b1;
    bus.vid_base  = base;
    bus.vid_len   = len;
    if (accept) begin
      a = base;
      for (int i = 0; i < int'(len); i++) begin
        e.data = model[a];
        e.last = (i == int'(len) - 1);
        vid_sb.push_back(e);
        a = a + 1'b1;
      end
    end
    step();
    bus.vid_start = 1'b0;
  endtask

  // CPU driver: one op presented per cycle, held while denied
  initial begin : cpu_drv
    cpu_op_t  op;
    cpu_exp_t e;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be = '0;
    bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    forever begin
      @(negedge clk); #1;
      if (cur_active) begin
        if (bus.cpu_ready) cur_active = 1'b0;
        else denials++;
      end
      if (!cur_active) begin
        if (cpu_ops.size() > 0) begin
          op = cpu_ops.pop_front();
          bus.cpu_req = 1'b1; bus.cpu_we = op.we; bus.cpu_be = op.be;
          bus.cpu_addr = op.addr; bus.cpu_wdata = op.data;
          if (op.we) model[op.addr] = merge(model[op.addr], op.data, op.be);
          e.we   = op.we;
          e.data = op.we ? '0 : model[op.addr];
          cpu_sb.push_back(e);
          cur_active = 1'b1;
        end else begin
          bus.cpu_req = 1'b0;
        end
      end
    end
  end

  // Output monitor / scoreboard comparison
  always @(negedge clk) begin : mon
    cpu_exp_t ce;
    vid_exp_t ve;
    if (bus.cpu_ready && bus.vid_valid) check("single_access", 64'(1), 64'(0));
    if (bus.cpu_ready) begin
      if (cpu_sb.size() == 0) check("cpu_ready_unexpected", 64'(1), 64'(0));
      else begin
        ce = cpu_sb.pop_front();
        if (!ce.we) check("cpu_rdata", 64'(bus.cpu_rdata), 64'(ce.data));
      end
    end
    if (bus.vid_valid) begin
      if (vid_sb.size() == 0) check("vid_valid_unexpected", 64'(1), 64'(0));
      else begin
        ve = vid_sb.pop_front();
        check("vid_data", 64'(bus.vid_data), 64'(ve.data));
        check("vid_last", 64'(bus.vid_last), 64'(ve.last));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0] exp3 [6];
    logic [1:0] exp2 [16];
    int k;
    reset = 1'b1;
    bus.vid_start = 1'b0; bus.vid_base = '0; bus.vid_len = '0;
    repeat (3) step();
    check("rst_vid_busy",  64'(bus.vid_busy),  64'(0));
    check("rst_vid_valid", 64'(bus.vid_valid), 64'(0));
    check("rst_vid_last",  64'(bus.vid_last),  64'(0));
    check("rst_cpu_ready", 64'(bus.cpu_ready), 64'(0));
    check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
    check("rst_vid_data",  64'(bus.vid_data),  64'(0));
    reset = 1'b0;
    step();

    // Basic write/read; idle CPU must never be denied
    denials = 0;
    cpu_wr(8'h10, 32'hDEADBEEF, 4'hF);
    cpu_rd(8'h10);
    wait_cpu_idle();
    check("cpu_idle_no_denial", 64'(denials), 64'(0));

    // Prefill every address the later tests read
    for (int i = 0; i < 256; i++)
      if (i != 'h10) cpu_wr(AW'(i), pat(AW'(i)), 4'hF);
    wait_cpu_idle();

    // Wrapping burst 0xFE..0x01, fresh writes first so video must see new data
    cpu_wr(8'hFE, 32'h0BAD_00FE, 4'hF);
    cpu_wr(8'h00, 32'h0BAD_0000, 4'hF);
    wait_cpu_idle();
    exp3[0] = 3'b001; exp3[1] = 3'b101; exp3[2] = 3'b101;
    exp3[3] = 3'b101; exp3[4] = 3'b110; exp3[5] = 3'b000;
    vid_burst(8'hFE, 8'd4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("burst_vlb_%0d", i),
            64'({bus.vid_valid, bus.vid_last, bus.vid_busy}), 64'(exp3[i]));
      step();
    end
    wait_vid_idle();

    // Continuous CPU reads during a 3-beat burst: 4 CPU slots per video beat
    denials = 0;
    for (int i = 0; i < 20; i++) cpu_rd(AW'(8'h60 + i));
    repeat (3) step();
    exp2[0] = 2'b10;
    for (int i = 1; i < 16; i++) exp2[i] = (i % 5 == 0) ? 2'b01 : 2'b10;
    vid_burst(8'h20, 8'd3, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("starve_cv_%0d", i), 64'({bus.cpu_ready, bus.vid_valid}), 64'(exp2[i]));
      step();
    end
    wait_cpu_idle();
    wait_vid_idle();
    check("starve_denials", 64'(denials), 64'(3));

    // Byte enables (macro-dependent expectation via the model)
    cpu_wr(8'h30, 32'h11223344, 4'hF);
    cpu_wr(8'h30, 32'hAAAAAAAA, 4'b0010);
    cpu_rd(8'h30);
    wait_cpu_idle();

    // Zero-length start is a no-op
    vid_burst(8'h00, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("zero_len_busy_%0d", i), 64'(bus.vid_busy), 64'(0));
      step();
    end

    // Start during an active burst is ignored
    vid_burst(8'h40, 8'd8, 1'b1);
    step();
    vid_burst(8'h80, 8'd5, 1'b0);
    check("restart_busy", 64'(bus.vid_busy), 64'(1));
    wait_vid_idle();

    // Reset mid-burst aborts it; memory survives
    cpu_rd(8'h31);
    wait_cpu_idle();
    vid_burst(8'h40, 8'd8, 1'b1);
    k = 0;
    while (!bus.vid_valid && k < 20) begin step(); k++; end
    check("abort_first_beat", 64'(bus.vid_valid), 64'(1));
    reset = 1'b1;
    vid_sb.delete();
    step();
    check("abort_vid_busy",  64'(bus.vid_busy),  64'(0));
    check("abort_vid_valid", 64'(bus.vid_valid), 64'(0));
    check("abort_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
    check("abort_vid_data",  64'(bus.vid_data),  64'(0));
    reset = 1'b0;
    repeat (5) step();
    check("abort_busy_after", 64'(bus.vid_busy), 64'(0));
    vid_burst(8'h50, 8'd2, 1'b1);
    wait_vid_idle();
    cpu_rd(8'h10);
    cpu_rd(8'h30);
    wait_cpu_idle();

    repeat (2) step();
    check("cpu_sb_empty", 64'(cpu_sb.size()), 64'(0));
    check("vid_sb_empty", 64'(vid_sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
